// File: rtl/ppu_pkg.sv
// Shared posit-unit definitions: field widths of a decoded posit, the decoded-field
// record carried between stages, and the output-register state encoding.
package ppu_pkg;

    localparam int POSIT_N = 16;
`ifdef NO_ES_FIELD
    localparam int POSIT_ES = 0;
`else
    localparam int POSIT_ES = 1;
`endif

    localparam int REG_LEN_SIZE = $clog2(POSIT_N) + 1;
    localparam int K_SIZE       = REG_LEN_SIZE + 1;
    localparam int MANT_SIZE    = POSIT_N;

    typedef struct packed {
        logic                    sign;
        logic                    reg_s;
        logic [REG_LEN_SIZE-1:0] reg_len;
        logic [K_SIZE-1:0]       k;
`ifndef NO_ES_FIELD
        logic [POSIT_ES-1:0]     exp;
`endif
        logic [MANT_SIZE-1:0]    mant;
        logic [1:0]              is_special;
    } decoded_posit_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/posit_decode.sv
// Combinational posit field extractor: sign, regime run, exponent and mantissa with
// the hidden one at the MSB. Negative posits are decoded from their two's complement.
module posit_decode
    import ppu_pkg::*;
(
    input  logic [POSIT_N-1:0] bits_i,
    output decoded_posit_t     dec_o
);

    localparam logic [REG_LEN_SIZE-1:0] RUN_MAX = REG_LEN_SIZE'(POSIT_N - 1);

    logic [POSIT_N-1:0]      abs_bits;
    logic [POSIT_N-2:0]      body;
    logic [POSIT_N-2:0]      rem;
    logic [REG_LEN_SIZE-1:0] run;
    logic [REG_LEN_SIZE-1:0] reg_len;
    logic                    run_done;

    assign abs_bits = bits_i[POSIT_N-1] ? -bits_i : bits_i;
    assign body     = abs_bits[POSIT_N-2:0];

    // NOTE: blocking assignments inside always_comb so each loop iteration sees the
    // previous iteration's run/run_done values.
    always_comb begin
        run      = '0;
        run_done = 1'b0;
        for (int i = POSIT_N - 2; i >= 0; i--) begin
            if (!run_done && (body[i] == body[POSIT_N-2])) begin
                run = run + REG_LEN_SIZE'(1);
            end else begin
                run_done = 1'b1;
            end
        end
    end

    // A regime that fills the whole body has no terminating bit.
    assign reg_len = (run == RUN_MAX) ? run : run + REG_LEN_SIZE'(1);
    assign rem     = body << reg_len;

    always_comb begin
        dec_o         = '0;
        dec_o.sign    = bits_i[POSIT_N-1];
        dec_o.reg_s   = body[POSIT_N-2];
        dec_o.reg_len = reg_len;
        dec_o.k       = body[POSIT_N-2] ? (K_SIZE'(run) - K_SIZE'(1)) : -K_SIZE'(run);
`ifdef NO_ES_FIELD
        dec_o.mant    = {1'b1, rem};
`else
        dec_o.exp     = rem[POSIT_N-2 -: POSIT_ES];
        dec_o.mant    = {1'b1, rem[POSIT_N-2-POSIT_ES:0], {POSIT_ES{1'b0}}};
`endif
        dec_o.is_special = {bits_i == '0, bits_i == {1'b1, {(POSIT_N-1){1'b0}}}};
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first valid requester at or above the
// pointer (wrapping); the pointer moves past the winner on every enabled grant.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic                     en_i,
    output logic [NREQ-1:0]          grant_o,
    output logic [$clog2(NREQ)-1:0]  grant_id_o
);

    localparam int ID_W = $clog2(NREQ);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;
    logic            found;

    always_comb begin
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!found && req_i[(int'(ptr_q) + off) % NREQ]) begin
                found      = 1'b1;
                grant_id_o = ID_W'((int'(ptr_q) + off) % NREQ);
            end
        end
        if (en_i && found) begin
            grant_o[grant_id_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = (int'(grant_id_o) == NREQ - 1) ? '0 : grant_id_o + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/posit_decode_sched.sv
// Shares one posit_decode among NREQ requesters; the round-robin winner is decoded into
// a one-entry id-tagged output register released over valid/ready at one result per clock.
module posit_decode_sched
    import ppu_pkg::*;
#(
    parameter int N    = POSIT_N,
    parameter int ES   = POSIT_ES,
    parameter int NREQ = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*N-1:0]        req_bits,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NREQ)-1:0]  out_id,
    output logic                     out_sign,
    output logic                     out_reg_s,
    output logic [REG_LEN_SIZE-1:0]  out_reg_len,
    output logic [K_SIZE-1:0]        out_k,
`ifndef NO_ES_FIELD
    output logic [ES-1:0]            out_exp,
`endif
    output logic [MANT_SIZE-1:0]     out_mant,
    output logic [1:0]               out_is_special
);

    localparam int ID_W = $clog2(NREQ);

    typedef struct packed {
        logic [ID_W-1:0] id;
        decoded_posit_t  fields;
    } out_reg_t;

    out_state_e      state_q;
    out_state_e      state_d;
    out_reg_t        out_q;
    out_reg_t        out_d;
    logic            can_accept;
    logic            accept;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_id;
    logic [N-1:0]    operand;
    decoded_posit_t  dec;

    assign out_valid  = (state_q == ST_FULL);
    assign can_accept = (state_q == ST_EMPTY) || (out_ready && out_valid);

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .en_i      (can_accept && rst),
        .grant_o   (grant),
        .grant_id_o(grant_id)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    always_comb begin
        operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            operand = operand | (req_bits[i*N +: N] & {N{grant[i]}});
        end
    end

    posit_decode u_dec (
        .bits_i(operand),
        .dec_o (dec)
    );

    // NOTE: every always_comb output gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (out_ready) state_d = accept ? ST_FULL : ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (accept) begin
            out_d.id     = grant_id;
            out_d.fields = dec;
        end
    end

    // NOTE: the output register is a handful of flops, not a memory, so its data is
    // cleared on reset along with the state; a result caught by reset is simply lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign out_id         = out_q.id;
    assign out_sign       = out_q.fields.sign;
    assign out_reg_s      = out_q.fields.reg_s;
    assign out_reg_len    = out_q.fields.reg_len;
    assign out_k          = out_q.fields.k;
`ifndef NO_ES_FIELD
    assign out_exp        = out_q.fields.exp;
`endif
    assign out_mant       = out_q.fields.mant;
    assign out_is_special = out_q.fields.is_special;

endmodule

// File: tb/tb_posit_decode_sched.sv
// Scoreboard bench for posit_decode_sched (N=16, ES=1, NREQ=2): a handshake model predicts
// grants and pushes table-derived decodes, which are compared while the result is held.
module tb_posit_decode_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_bits;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_id;
    logic        out_sign;
    logic        out_reg_s;
    logic [4:0]  out_reg_len;
    logic [5:0]  out_k;
    logic [0:0]  out_exp;
    logic [15:0] out_mant;
    logic [1:0]  out_is_special;

    posit_decode_sched #(
        .N   (16),
        .ES  (1),
        .NREQ(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_bits      (req_bits),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_id        (out_id),
        .out_sign      (out_sign),
        .out_reg_s     (out_reg_s),
        .out_reg_len   (out_reg_len),
        .out_k         (out_k),
        .out_exp       (out_exp),
        .out_mant      (out_mant),
        .out_is_special(out_is_special)
    );

    typedef struct {
        int          id;
        logic        sign;
        logic        reg_s;
        logic [4:0]  reg_len;
        logic [5:0]  k;
        logic        exp;
        logic [15:0] mant;
        logic [1:0]  spec;
        bit          only_special;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   m_full   = 1'b0;
    int   m_ptr    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Hand-derived decodes of every operand the stimulus uses.
    function automatic exp_t lookup(input logic [15:0] b, input int id);
        exp_t e;
        e.id = id; e.sign = 1'b0; e.reg_s = 1'b0; e.reg_len = 5'd0; e.k = 6'd0;
        e.exp = 1'b0; e.mant = 16'h8000; e.spec = 2'b00; e.only_special = 1'b0;
        case (b)
            16'h4000: begin e.reg_s = 1'b1; e.reg_len = 5'd2; end
            16'h5000: begin e.reg_s = 1'b1; e.reg_len = 5'd2; e.exp = 1'b1; end
            16'hC000: begin e.sign = 1'b1; e.reg_s = 1'b1; e.reg_len = 5'd2; end
            16'hB000: begin e.sign = 1'b1; e.reg_s = 1'b1; e.reg_len = 5'd2; e.exp = 1'b1; end
            16'h7FFF: begin e.reg_s = 1'b1; e.reg_len = 5'd15; e.k = 6'd14; end
            16'h0001: begin e.reg_len = 5'd15; e.k = 6'h32; end
            16'h4A00: begin e.reg_s = 1'b1; e.reg_len = 5'd2; e.mant = 16'hD000; end
            16'h3400: begin e.reg_len = 5'd2; e.k = 6'h3F; e.exp = 1'b1; e.mant = 16'hA000; end
            16'h0000: begin e.spec = 2'b10; e.only_special = 1'b1; end
            16'h8000: begin e.sign = 1'b1; e.spec = 2'b01; e.only_special = 1'b1; end
            default:  begin e.spec = 2'b11; end
        endcase
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [15:0] b0, input logic [15:0] b1,
                         input logic rdy);
        req_valid = v;
        req_bits  = {b1, b0};
        out_ready = rdy;
    endtask

    // Called just after a falling edge with inputs already driven; samples, then steps.
    task automatic cycle(input bit chk_zero = 1'b0);
        logic [1:0] exp_ready;
        bit         accept;
        int         gid;
        int         idx;
        exp_t       head;
        #2;
        exp_ready = 2'b00;
        accept    = 1'b0;
        gid       = 0;
        if (rst === 1'b1 && (!m_full || out_ready === 1'b1)) begin
            for (int off = 0; off < 2; off++) begin
                idx = (m_ptr + off) % 2;
                if (!accept && req_valid[idx]) begin
                    accept = 1'b1;
                    gid    = idx;
                end
            end
        end
        if (accept) exp_ready[gid] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            head = exp_q[0];
            check("out_id", 32'(out_id), 32'(head.id));
            check("out_sign", 32'(out_sign), 32'(head.sign));
            check("out_is_special", 32'(out_is_special), 32'(head.spec));
            if (!head.only_special) begin
                check("out_reg_s", 32'(out_reg_s), 32'(head.reg_s));
                check("out_reg_len", 32'(out_reg_len), 32'(head.reg_len));
                check("out_k", 32'(out_k), 32'(head.k));
                check("out_exp", 32'(out_exp), 32'(head.exp));
                check("out_mant", 32'(out_mant), 32'(head.mant));
            end
        end
        if (chk_zero) begin
            check("rst_out_id", 32'(out_id), 32'd0);
            check("rst_out_sign", 32'(out_sign), 32'd0);
            check("rst_out_reg_s", 32'(out_reg_s), 32'd0);
            check("rst_out_reg_len", 32'(out_reg_len), 32'd0);
            check("rst_out_k", 32'(out_k), 32'd0);
            check("rst_out_exp", 32'(out_exp), 32'd0);
            check("rst_out_mant", 32'(out_mant), 32'd0);
            check("rst_out_is_special", 32'(out_is_special), 32'd0);
        end
        if (rst !== 1'b1) begin
            m_full = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
        end else begin
            if (m_full && out_ready === 1'b1) begin
                void'(exp_q.pop_front());
                m_full = 1'b0;
            end
            if (accept) begin
                exp_q.push_back(lookup(req_bits[gid*16 +: 16], gid));
                m_full = 1'b1;
                m_ptr  = (gid + 1) % 2;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(2'b11, 16'h4000, 16'h0000, 1'b1);
        @(negedge clk);

        // Reset held with both requesters asking.
        repeat (3) cycle(1'b1);
        rst = 1'b1;
        drive(2'b00, 16'h0000, 16'h0000, 1'b1);
        cycle();

        // Single request from requester 0.
        drive(2'b01, 16'h4000, 16'h0000, 1'b1);
        cycle();
        drive(2'b00, 16'h4000, 16'h0000, 1'b1);
        cycle();
        cycle();

        // NaR from requester 1.
        drive(2'b10, 16'h0000, 16'h8000, 1'b1);
        cycle();
        drive(2'b00, 16'h0000, 16'h8000, 1'b1);
        cycle();
        cycle();

        // Contention at full throughput: ids alternate every cycle.
        drive(2'b11, 16'h5000, 16'h0000, 1'b1);
        repeat (6) cycle();
        drive(2'b11, 16'hC000, 16'h7FFF, 1'b1);
        repeat (2) cycle();
        drive(2'b11, 16'h0001, 16'hB000, 1'b1);
        repeat (2) cycle();
        drive(2'b00, 16'h0000, 16'h0000, 1'b1);
        repeat (2) cycle();

        // Back-pressure; requester 1 briefly withdraws, then drain+reload with no bubble.
        drive(2'b01, 16'h4A00, 16'h3400, 1'b0);
        cycle();
        drive(2'b10, 16'h4A00, 16'h3400, 1'b0);
        cycle();
        drive(2'b00, 16'h4A00, 16'h3400, 1'b0);
        cycle();
        drive(2'b10, 16'h4A00, 16'h3400, 1'b0);
        repeat (2) cycle();
        drive(2'b10, 16'h4A00, 16'h3400, 1'b1);
        cycle();
        drive(2'b00, 16'h4A00, 16'h3400, 1'b1);
        repeat (2) cycle();

        // Reset while full and stalled: the held result must vanish.
        drive(2'b01, 16'h5000, 16'h0000, 1'b0);
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        drive(2'b00, 16'h5000, 16'h0000, 1'b1);
        cycle(1'b1);
        drive(2'b11, 16'h4000, 16'h0000, 1'b1);
        repeat (2) cycle();
        drive(2'b00, 16'h4000, 16'h0000, 1'b1);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
